// File: rtl/conv_result_collector.sv
// Dual-port result sink: FIFO-buffers 0/1/2 words per cycle and serialises them with row/column tags.
// Optional build macro CONV_COLLECT_RELU_EN applies ReLU to out_data on the read side.
module conv_result_collector #(
    parameter int DATA_WIDTH = 25,
    parameter int DEPTH      = 61,
    parameter int ROWS       = 5,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] in_port0,
    input  logic                  in_port0_vld,
    input  logic [DATA_WIDTH-1:0] in_port1,
    input  logic                  in_port1_vld,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_col,
    output logic [2:0]            out_row,
    output logic                  out_last,
    output logic                  frame_done,
    output logic                  overflow,
    output logic                  proto_err
);

    localparam int              AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW+1:0]   FULL    = (AW+2)'(FIFO_DEPTH);
    localparam logic [7:0]      COL_MAX = 8'(DEPTH - 1);
    localparam logic [2:0]      ROW_MAX = 3'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state, state_nxt;
    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [AW:0]             wr_ptr, rd_ptr, count;
    logic [AW-1:0]           wr_idx0, wr_idx1;
    logic [AW+1:0]           need;
    logic [1:0]              n;
    logic [7:0]              col;
    logic [2:0]              row;
    logic [DATA_WIDTH-1:0]   head;
    logic                    start_ok, do_push, drop, proto, pop, is_last;

    assign count    = wr_ptr - rd_ptr;
    assign n        = {1'b0, in_port0_vld} + {1'b0, in_port0_vld & in_port1_vld};
    // Space check uses occupancy at cycle start; a same-cycle pop is deliberately not credited.
    assign need     = {1'b0, count} + {{AW{1'b0}}, n};
    assign start_ok = (state == IDLE) && start;
    assign do_push  = (state == RUN) && (n != 2'd0) && (need <= FULL);
    assign drop     = (state == RUN) && (n != 2'd0) && (need > FULL);
    assign proto    = (state == RUN) && in_port1_vld && !in_port0_vld;
    assign wr_idx0  = wr_ptr[AW-1:0];
    assign wr_idx1  = wr_idx0 + AW'(1);
    assign head     = mem[rd_ptr[AW-1:0]];

    assign out_valid  = (state == RUN) && (count != '0);
    assign pop        = out_valid && out_ready;
    assign is_last    = (row == ROW_MAX) && (col == COL_MAX);
    assign out_last   = out_valid && is_last;
    assign frame_done = (state == DONE);
    assign out_col    = col;
    assign out_row    = row;

`ifdef CONV_COLLECT_RELU_EN
    assign out_data = (out_valid && !head[DATA_WIDTH-1]) ? head : '0;
`else
    assign out_data = out_valid ? head : '0;
`endif

    always_comb begin
        // NOTE: default assigned first so every path drives state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (pop && is_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            col       <= '0;
            row       <= '0;
            overflow  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (do_push)
                wr_ptr <= wr_ptr + {{(AW-1){1'b0}}, n};
            // Leftover words are flushed while passing through DONE.
            if (state == DONE)
                rd_ptr <= wr_ptr;
            else if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
            if (start_ok || (pop && is_last)) begin
                col <= '0;
                row <= '0;
            end else if (pop) begin
                if (col == COL_MAX) begin
                    col <= '0;
                    row <= row + 3'd1;
                end else begin
                    col <= col + 8'd1;
                end
            end
            if (start_ok)
                overflow <= 1'b0;
            else if (drop)
                overflow <= 1'b1;
            if (start_ok)
                proto_err <= 1'b0;
            else if (proto)
                proto_err <= 1'b1;
        end
    end

    // NOTE: storage is not reset; out_data is gated by out_valid so stale entries never escape.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx0] <= in_port0;
            if (n == 2'd2)
                mem[wr_idx1] <= in_port1;
        end
    end

endmodule
